regfile_mp: RTL and testbench



---
 rtl/regfile_mp.sv | 90 +++++++++
 tb/tb_regfile_mp.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file with soft-clear FSM; optional REGFILE_MP_BYPASS_EN write-to-read bypass
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NRD*ADDR_W-1:0]    rd_addr,
    output logic [NRD*DATA_W-1:0]    rd_data,
    input  logic                     wa_en,
    input  logic                     wb_en,
    input  logic [ADDR_W-1:0]        wa_addr,
    input  logic [ADDR_W-1:0]        wb_addr,
    input  logic [DATA_W-1:0]        wa_data,
    input  logic [DATA_W-1:0]        wb_data,
    input  logic                     clr_req,
    output logic                     busy,
    output logic                     clr_done,
    output logic                     wr_drop
);

    localparam int DEPTH = 2**ADDR_W;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t             state;
    logic [ADDR_W-1:0]  index;
    logic [DATA_W-1:0]  regs [DEPTH];
    logic               wa_ok;
    logic               wb_ok;

    assign wa_ok = wa_en && !(ZERO_REG != 0 && wa_addr == '0);
    assign wb_ok = wb_en && !(ZERO_REG != 0 && wb_addr == '0);
    assign busy  = (state == CLEAR);

    // Port B is written after port A so it wins on an address collision.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            index    <= '0;
            clr_done <= 1'b0;
            wr_drop  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else begin
            clr_done <= 1'b0;
            wr_drop  <= 1'b0;
            case (state)
                IDLE: begin
                    if (wa_ok) regs[wa_addr] <= wa_data;
                    if (wb_ok) regs[wb_addr] <= wb_data;
                    if (clr_req) begin
                        state <= CLEAR;
                        index <= '0;
                    end
                end
                CLEAR: begin
                    regs[index] <= '0;
                    index       <= index + 1'b1;
                    wr_drop     <= wa_en | wb_en;
                    if (index == {ADDR_W{1'b1}}) begin
                        state    <= IDLE;
                        clr_done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] stored;
        assign ra     = rd_addr[k*ADDR_W +: ADDR_W];
        assign stored = (ZERO_REG != 0 && ra == '0) ? '0 : regs[ra];
`ifdef REGFILE_MP_BYPASS_EN
        logic byp_ok;
        assign byp_ok = !busy && !(ZERO_REG != 0 && ra == '0);
        assign rd_data[k*DATA_W +: DATA_W] =
            (byp_ok && wb_en && wb_addr == ra) ? wb_data :
            (byp_ok && wa_en && wa_addr == ra) ? wa_data : stored;
`else
        assign rd_data[k*DATA_W +: DATA_W] = stored;
`endif
    end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - randomized and directed self-checking bench for regfile_mp
module tb_regfile_mp;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NRD    = 2;
    localparam int DEPTH  = 32;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [NRD*ADDR_W-1:0]  rd_addr;
    logic [NRD*DATA_W-1:0]  rd_data;
    logic                   wa_en, wb_en;
    logic [ADDR_W-1:0]      wa_addr, wb_addr;
    logic [DATA_W-1:0]      wa_data, wb_data;
    logic                   clr_req, busy, clr_done, wr_drop;

    regfile_mp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NRD(NRD), .ZERO_REG(1)) dut (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data),
        .wa_en(wa_en), .wb_en(wb_en), .wa_addr(wa_addr), .wb_addr(wb_addr),
        .wa_data(wa_data), .wb_data(wb_data), .clr_req(clr_req),
        .busy(busy), .clr_done(clr_done), .wr_drop(wr_drop)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference: array contents plus "how many registers the clear has swept so far".
    logic [DATA_W-1:0] mem [DEPTH];
    bit m_busy, m_done, m_drop;
    int cleared;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DATA_W-1:0] exp_read(input int a);
        if (a == 0) return '0;
`ifdef REGFILE_MP_BYPASS_EN
        if (!m_busy) begin
            if (wb_en && int'(wb_addr) == a) return wb_data;
            if (wa_en && int'(wa_addr) == a) return wa_data;
        end
`endif
        if (m_busy && a < cleared) return '0;
        return mem[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        m_busy = 0; m_done = 0; m_drop = 0; cleared = 0;
    endtask

    task automatic model_edge();
        if (m_busy) begin
            m_drop = wa_en | wb_en;
            m_done = 0;
            cleared++;
            if (cleared == DEPTH) begin
                for (int i = 0; i < DEPTH; i++) mem[i] = '0;
                m_busy = 0;
                m_done = 1;
            end
        end else begin
            m_drop = 0;
            m_done = 0;
            if (wa_en && wa_addr != 0) mem[wa_addr] = wa_data;
            if (wb_en && wb_addr != 0) mem[wb_addr] = wb_data;
            if (clr_req) begin
                m_busy  = 1;
                cleared = 0;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        for (int k = 0; k < NRD; k++) begin
            check_eq($sformatf("rd%0d", k), rd_data[k*DATA_W +: DATA_W],
                     exp_read(int'(rd_addr[k*ADDR_W +: ADDR_W])));
        end
        check_eq("busy", busy, m_busy);
        check_eq("clr_done", clr_done, m_done);
        check_eq("wr_drop", wr_drop, m_drop);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        wa_en = 0; wb_en = 0; clr_req = 0;
        wa_addr = '0; wb_addr = '0; wa_data = '0; wb_data = '0;
    endtask

    task automatic set_rd(input int p0, input int p1);
        rd_addr[0 +: ADDR_W]      = ADDR_W'(p0);
        rd_addr[ADDR_W +: ADDR_W] = ADDR_W'(p1);
    endtask

    int nb, nd, ndrop;
    logic [DATA_W-1:0] old3;

    initial begin
        idle_inputs();
        rd_addr = '0;
        reset   = 1'b1;
        model_reset();
        #12;
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", clr_done, 0);
        check_eq("rst_drop", wr_drop, 0);
        check_eq("rst_rd", rd_data, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Write A to reg 5, read it on both ports
        wa_en = 1; wa_addr = 5; wa_data = 32'hDEADBEEF;
        tick();
        idle_inputs(); set_rd(5, 5); #1;
        check_eq("r5_p0", rd_data[0 +: DATA_W], 32'hDEADBEEF);
        check_eq("r5_p1", rd_data[DATA_W +: DATA_W], 32'hDEADBEEF);
        tick();

        // Same-address collision, B wins, no drop
        wa_en = 1; wa_addr = 7; wa_data = 32'h1111;
        wb_en = 1; wb_addr = 7; wb_data = 32'h2222;
        tick();
        idle_inputs(); set_rd(7, 0); #1;
        check_eq("r7_bwins", rd_data[0 +: DATA_W], 32'h2222);
        check_eq("r7_nodrop", wr_drop, 0);
        tick();

        // Writes to reg 0 are ignored, with or without bypass
        wa_en = 1; wa_addr = 0; wa_data = 32'h5; set_rd(0, 0); #1;
        check_eq("r0_same", rd_data[0 +: DATA_W], 0);
        tick();
        idle_inputs(); #1;
        check_eq("r0_after", rd_data[0 +: DATA_W], 0);
        tick();

        // Same-cycle read of a register being written
        old3 = mem[3];
        wa_en = 1; wa_addr = 3; wa_data = 32'hCAFE; set_rd(3, 3); #1;
`ifdef REGFILE_MP_BYPASS_EN
        check_eq("r3_bypass", rd_data[0 +: DATA_W], 32'hCAFE);
`else
        check_eq("r3_nobypass", rd_data[0 +: DATA_W], old3);
`endif
        tick();
        idle_inputs(); #1;
        check_eq("r3_after", rd_data[DATA_W +: DATA_W], 32'hCAFE);

        // Fill all registers, then clear with wa_en held high
        for (int i = 0; i < DEPTH; i++) begin
            wa_en = 1; wa_addr = ADDR_W'(i); wa_data = $urandom; set_rd(i, (i + 1) % DEPTH);
            tick();
        end
        wa_en = 1; wa_addr = 9; wa_data = $urandom; clr_req = 1;
        tick();
        clr_req = 0;
        nb = 0; nd = 0; ndrop = 0;
        for (int i = 0; i < 35; i++) begin
            if (busy) nb++;
            if (clr_done) nd++;
            if (wr_drop) ndrop++;
            wa_data = $urandom; set_rd($urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH - 1));
            tick();
        end
        check_eq("clr_busy_cycles", nb, 32);
        check_eq("clr_done_count", nd, 1);
        check_eq("clr_drop_count", ndrop, 32);
        idle_inputs();
        for (int i = 0; i < DEPTH; i += 2) begin
            set_rd(i, i + 1);
            tick();
        end

        // Reset in the middle of a clear
        for (int i = 1; i < DEPTH; i++) begin
            wa_en = 1; wa_addr = ADDR_W'(i); wa_data = $urandom | 1;
            tick();
        end
        idle_inputs(); clr_req = 1;
        tick();
        clr_req = 0; wa_en = 1; wa_addr = 4;
        for (int i = 0; i < 10; i++) tick();
        reset = 1'b1;
        #1;
        check_eq("abort_busy", busy, 0);
        check_eq("abort_done", clr_done, 0);
        check_eq("abort_drop", wr_drop, 0);
        nb = 0;
        for (int i = 0; i < DEPTH; i++) begin
            set_rd(i, i); #0.1;
            if (rd_data != '0) nb++;
        end
        check_eq("abort_regs_nonzero", nb, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        idle_inputs();
        for (int i = 0; i < 40; i++) begin
            set_rd(i % DEPTH, (i + 7) % DEPTH);
            tick();
        end

        // Randomized traffic with occasional clears
        for (int i = 0; i < 1500; i++) begin
            wa_en   = ($urandom_range(0, 3) != 0);
            wb_en   = ($urandom_range(0, 2) == 0);
            wa_addr = ($urandom_range(0, 1) != 0) ? ADDR_W'($urandom_range(0, 7)) : ADDR_W'($urandom);
            wb_addr = ($urandom_range(0, 1) != 0) ? ADDR_W'($urandom_range(0, 7)) : ADDR_W'($urandom);
            wa_data = $urandom;
            wb_data = $urandom;
            clr_req = ($urandom_range(0, 79) == 0);
            set_rd($urandom_range(0, 1) != 0 ? int'(wa_addr) : $urandom_range(0, DEPTH - 1),
                   $urandom_range(0, 1) != 0 ? int'(wb_addr) : $urandom_range(0, DEPTH - 1));
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
